pe_feeder: RTL
==============

// Module: pe_feeder
// PURPOSE
//  Upstream sequencer for the parallel PE. Reads 512-bit neuron/weight chunks from two single-port
//  SRAMs and drives the PE's neuron/weight/ctl/vld_i inputs for OUT_NUM dot products of CHUNK_NUM chunks each.
//  Collects the PE's vld_o/result stream, tags each result with its output index and signals completion.
//  Sits between the on-chip buffers and parallel_pe inside the PE cluster.
// PARAMETERS
//  DATA_W   512  chunk width (neuron and weight)
//  ADDR_W   10   SRAM word address width
//  CNT_W    8    width of chunk_num / out_num / counters
// PORTS
//  clk            in   1        clock; all logic on posedge
//  rst            in   1        synchronous reset, active-high
//  start          in   1        1-cycle launch pulse, sampled only in IDLE
//  neuron_base    in   ADDR_W   first neuron chunk address
//  weight_base    in   ADDR_W   first weight chunk address
//  chunk_num      in   CNT_W    chunks per dot product
//  out_num        in   CNT_W    number of dot products (output neurons)
//  nrn_ren        out  1        neuron SRAM read enable
//  nrn_raddr      out  ADDR_W   neuron SRAM read address
//  nrn_rdata      in   DATA_W   neuron SRAM data, valid 1 cycle after nrn_ren
//  wgt_ren        out  1        weight SRAM read enable
//  wgt_raddr      out  ADDR_W   weight SRAM read address
//  wgt_rdata      in   DATA_W   weight SRAM data, valid 1 cycle after wgt_ren
//  pe_neuron      out  DATA_W   = nrn_rdata (pass-through)
//  pe_weight      out  DATA_W   = wgt_rdata (pass-through)
//  pe_ctl         out  2        [0]=first chunk (restart psum), [1]=last chunk (emit result)
//  pe_vld_i       out  1        chunk valid to PE
//  pe_result      in   32       PE partial/final sum
//  pe_vld_o       in   1        PE result valid
//  res_data       out  32       = pe_result
//  res_vld        out  1        = pe_vld_o while busy
//  res_idx        out  CNT_W    output index of current res_data (0..out_num-1)
//  busy           out  1        high from cycle after accepted start until done
//  done           out  1        1-cycle completion pulse
// BEHAVIOUR
//  Reset: state IDLE; nrn_ren, wgt_ren, pe_vld_i, pe_ctl, busy, done, res_idx = 0; addresses = 0.
//  FSM: IDLE -start-> ISSUE -last read issued-> DRAIN -final pe_vld_o-> DONE -> IDLE (1 cycle).
//  start: latches bases and counts; ignored outside IDLE. chunk_num==0 or out_num==0 -> go
//    straight to DONE: no reads, no pe_vld_i, done one cycle after start.
//  ISSUE: one read per cycle on both SRAMs, no bubbles; chunk_idx 0..chunk_num-1, out_idx 0..out_num-1.
//    nrn_raddr = neuron_base + chunk_idx (same neuron vector reused per output).
//    wgt_raddr = weight_base + out_idx*chunk_num + chunk_idx (linear pointer, +1 per read).
//    Address arithmetic is modulo 2^ADDR_W (wrap, no error).
//  Read pipeline: ctl tags computed at issue, registered 1 cycle, so pe_vld_i/pe_ctl align with rdata.
//    pe_ctl[0]=1 on chunk_idx==0; pe_ctl[1]=1 on chunk_idx==chunk_num-1; chunk_num==1 -> 2'b11.
//    pe_vld_i=0 -> pe_ctl=0.
//  Results: res_vld = pe_vld_o & busy; res_idx increments after each res_vld; pe_vld_o while
//    not busy is ignored. Final result = out_num-th res_vld; done asserts next cycle, busy drops same cycle.
//  Latency (start sampled edge 0): reads cycles 1..N (N=chunk_num*out_num), pe_vld_i 2..N+1,
//    last pe_vld_o N+2, done N+3.
//  start coincident with done: ignored (DONE not IDLE). rst mid-operation: abort immediately to
//    reset values; in-flight SRAM data and PE results discarded.
// TESTING
//  1 chunk_num=4,out_num=2,bases 0/0x10: ren cycles 1..8; wgt_raddr 0x10..0x17, nrn_raddr 0,1,2,3,0,1,2,3;
//    pe_ctl[0] at 2,6, pe_ctl[1] at 5,9; res_vld at 6,10 with idx 0,1; done at 11.
//  2 chunk_num=1,out_num=3: pe_ctl=2'b11 on every pe_vld_i; 3 results idx 0..2; done at cycle 6.
//  3 out_num=0 (and separately chunk_num=0): no ren, no pe_vld_i; done pulse at cycle 1; busy stays 0.
//  4 weight_base=0x3FE, chunk_num=4,out_num=1: wgt_raddr 0x3FE,0x3FF,0x000,0x001 (wrap).
//  5 start re-pulsed while busy and in the done cycle: no effect; run identical to scenario 1.
//  6 rst asserted at cycle 4 of scenario 1: next cycle all outputs 0, IDLE; fresh start runs cleanly.

Source files
------------

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - SRAM-to-PE chunk sequencer with result tagging
//
// Purpose: reads neuron/weight chunks from two single-port SRAMs and drives the
// PE for out_num dot products of chunk_num chunks each, then tags PE results
// with their output index and pulses done after the last one.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    launch pulse, only honoured in IDLE
//   neuron_base/weight_base  first chunk addresses (latched at start)
//   chunk_num/out_num        chunks per dot product / number of dot products
//   nrn_ren/nrn_raddr/nrn_rdata   neuron SRAM port (1-cycle read latency)
//   wgt_ren/wgt_raddr/wgt_rdata   weight SRAM port (1-cycle read latency)
//   pe_neuron/pe_weight/pe_ctl/pe_vld_i   chunk stream to the PE
//   pe_result/pe_vld_o       result stream from the PE
//   res_data/res_vld/res_idx tagged result stream
//   busy/done                run status
module pe_feeder #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [CNT_W-1:0]  chunk_num,
  input  logic [CNT_W-1:0]  out_num,
  output logic              nrn_ren,
  output logic [ADDR_W-1:0] nrn_raddr,
  input  logic [DATA_W-1:0] nrn_rdata,
  output logic              wgt_ren,
  output logic [ADDR_W-1:0] wgt_raddr,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic [DATA_W-1:0] pe_neuron,
  output logic [DATA_W-1:0] pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld_i,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld_o,
  output logic [31:0]       res_data,
  output logic              res_vld,
  output logic [CNT_W-1:0]  res_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  nbase_q;
  logic [ADDR_W-1:0]  wptr_q;
  logic [CNT_W-1:0]   cnum_q;
  logic [CNT_W-1:0]   onum_q;
  logic [CNT_W-1:0]   chunk_idx;
  logic [CNT_W-1:0]   out_idx;
  logic               issue;
  logic               last_chunk;
  logic               last_read;
  logic               final_res;
  logic               launch;

  assign issue      = (state == ISSUE);
  assign launch     = (state == IDLE) && start;
  assign last_chunk = (chunk_idx == cnum_q - CNT_W'(1));
  assign last_read  = last_chunk && (out_idx == onum_q - CNT_W'(1));
  assign final_res  = res_vld && (res_idx == onum_q - CNT_W'(1));

  // Addresses are forced to 0 when no read is issued so idle outputs stay quiet.
  assign nrn_ren   = issue;
  assign wgt_ren   = issue;
  assign nrn_raddr = issue ? nbase_q + ADDR_W'(chunk_idx) : '0;
  assign wgt_raddr = issue ? wptr_q : '0;

  assign pe_neuron = nrn_rdata;
  assign pe_weight = wgt_rdata;

  assign busy     = (state == ISSUE) || (state == DRAIN);
  assign done     = (state == DONE);
  assign res_data = pe_result;
  assign res_vld  = pe_vld_o && busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (chunk_num == '0 || out_num == '0) ? DONE : ISSUE;
      ISSUE: if (last_read) state_next = DRAIN;
      DRAIN: if (final_res) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nbase_q   <= '0;
      wptr_q    <= '0;
      cnum_q    <= '0;
      onum_q    <= '0;
      chunk_idx <= '0;
      out_idx   <= '0;
      res_idx   <= '0;
      pe_vld_i  <= 1'b0;
      pe_ctl    <= 2'b00;
    end else begin
      // Tags are computed at issue and delayed one cycle to line up with rdata.
      pe_vld_i <= issue;
      pe_ctl   <= issue ? {last_chunk, chunk_idx == '0} : 2'b00;

      if (launch) begin
        nbase_q   <= neuron_base;
        wptr_q    <= weight_base;
        cnum_q    <= chunk_num;
        onum_q    <= out_num;
        chunk_idx <= '0;
        out_idx   <= '0;
      end else if (issue) begin
        // Weights are laid out contiguously, so a linear pointer covers
        // weight_base + out_idx*chunk_num + chunk_idx without a multiplier.
        wptr_q <= wptr_q + ADDR_W'(1);
        if (last_chunk) begin
          chunk_idx <= '0;
          out_idx   <= out_idx + CNT_W'(1);
        end else begin
          chunk_idx <= chunk_idx + CNT_W'(1);
        end
      end

      if (state == DONE)  res_idx <= '0;
      else if (res_vld)   res_idx <= res_idx + CNT_W'(1);
    end
  end

endmodule
